// File: rtl/tlc5620_ch_sched.sv
// tlc5620_ch_sched: round-robin four-channel update scheduler and serial driver for the TLC5620 DAC.
// Define TLC5620_SYNC_LDAC_EN to batch DA_LDAC across bursts of updates (at most 3 deferrals).
module tlc5620_ch_sched #(
    parameter int CLK_DIV = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req,
    input  logic [31:0] ch_data,
    input  logic [3:0]  ch_rng,
    output logic [3:0]  ack,
    output logic        busy,
    output logic        DA_IO_CLK,
    output logic        DA_OUT_DATA,
    output logic        DA_LOAD,
    output logic        DA_LDAC
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {IDLE, SHIFT, LOAD, LDAC, GAP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [4:0] half;
    logic [10:0] sr;
    logic [1:0] p, g;
    logic tick, defer;
    assign tick = cnt == CW'(CLK_DIV - 1);
    always_comb begin
        g = p;
        // Descending scan so the candidate closest to p wins.
        for (int k = 3; k >= 0; k--)
            if (req[p + 2'(k)]) g = p + 2'(k);
    end
`ifdef TLC5620_SYNC_LDAC_EN
    logic [1:0] dcnt;
    assign defer = |req && dcnt != 2'd3;
    always_ff @(posedge sys_clk)
        if (sys_rst) dcnt <= '0;
        else if (state == LOAD && tick) dcnt <= defer ? dcnt + 2'd1 : 2'd0;
`else
    assign defer = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = |req ? SHIFT : IDLE;
            SHIFT:   state_nx = (tick && half == 5'd21) ? LOAD : SHIFT;
            LOAD:    state_nx = tick ? (defer ? GAP : LDAC) : LOAD;
            LDAC:    state_nx = tick ? GAP : LDAC;
            GAP:     state_nx = tick ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            cnt   <= '0;
            half  <= '0;
            sr    <= '0;
            p     <= '0;
            ack   <= '0;
        end else begin
            state <= state_nx;
            ack   <= (state == IDLE && |req) ? 4'b0001 << g : 4'b0000;
            cnt   <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            if (state == IDLE) begin
                half <= '0;
                if (|req) begin
                    sr <= {g, ch_rng[g], ch_data[{g, 3'b000} +: 8]};
                    p  <= g + 2'd1;
                end
            end else if (state == SHIFT && tick) begin
                half <= half + 5'd1;
                if (half[0]) sr <= {sr[9:0], 1'b0};
            end
        end
    end
    assign busy        = state != IDLE;
    assign DA_IO_CLK   = state == SHIFT && !half[0];
    assign DA_OUT_DATA = state == SHIFT && sr[10];
    assign DA_LOAD     = state != LOAD;
    assign DA_LDAC     = state != LDAC;
endmodule

// File: tb/tb_tlc5620_ch_sched.sv
// tb_tlc5620_ch_sched: directed vectors for tlc5620_ch_sched at CLK_DIV=4; expectations computed by hand.
module tb_tlc5620_ch_sched;
    logic sys_clk = 0, sys_rst = 1;
    logic [3:0] req = 0, ch_rng = 0, ack;
    logic [31:0] ch_data = 0;
    logic busy, DA_IO_CLK, DA_OUT_DATA, DA_LOAD, DA_LDAC;
    int vec_n = 0, err_n = 0;
    int cyc_n = 0, bit_n = 0, load_n = 0, ldac_n = 0, ack_n = 0;
    logic [10:0] bits = 0;
    logic [3:0] ack_log [0:15];
    int ack_t [0:15];
    logic prev_clk = 0, prev_load = 1, prev_ldac = 1, drop = 0;

    tlc5620_ch_sched #(.CLK_DIV(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .ch_data(ch_data), .ch_rng(ch_rng),
        .ack(ack), .busy(busy), .DA_IO_CLK(DA_IO_CLK), .DA_OUT_DATA(DA_OUT_DATA),
        .DA_LOAD(DA_LOAD), .DA_LDAC(DA_LDAC)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: observe outputs at the falling edge, then let requesters drop acked requests.
    task automatic step();
        @(negedge sys_clk);
        cyc_n++;
        if (prev_clk && !DA_IO_CLK) begin
            bits = {bits[9:0], DA_OUT_DATA};
            bit_n++;
        end
        if (prev_load && !DA_LOAD) load_n++;
        if (prev_ldac && !DA_LDAC) ldac_n++;
        if (ack != 0 && ack_n < 16) begin
            ack_log[ack_n] = ack;
            ack_t[ack_n] = cyc_n;
            ack_n++;
        end
        prev_clk = DA_IO_CLK;
        prev_load = DA_LOAD;
        prev_ldac = DA_LDAC;
        if (drop) req = req & ~ack;
    endtask

    task automatic clear_mon();
        bit_n = 0; load_n = 0; ldac_n = 0; ack_n = 0; bits = 0;
    endtask

    task automatic do_reset();
        sys_rst = 1;
        repeat (3) step();
        sys_rst = 0;
        clear_mon();
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 400 && (busy || req != 0); i++) step();
        if (i == 400) check({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        int lf, ll, df, dl, i;
        // Reset values
        req = 0;
        do_reset();
        check("rst_ioclk", DA_IO_CLK, 0);
        check("rst_data", DA_OUT_DATA, 0);
        check("rst_load", DA_LOAD, 1);
        check("rst_ldac", DA_LDAC, 1);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);

        // Single update: ch2, code A5, 2x range
        drop = 1;
        ch_data[23:16] = 8'hA5;
        ch_rng = 4'b0100;
        req = 4'b0100;
        step();
        check("single_ack", ack, 4'b0100);
        check("single_busy", busy, 1);
        check("single_ioclk", DA_IO_CLK, 1);
        lf = -1; ll = 0; df = -1; dl = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (!DA_LOAD) begin if (lf < 0) lf = k; ll++; end
            if (!DA_LDAC) begin if (df < 0) df = k; dl++; end
        end
        check("single_bits", bits, 11'b10110100101);
        check("single_nbits", bit_n, 11);
        check("load_first", lf, 88);
        check("load_len", ll, 4);
        check("ldac_first", df, 92);
        check("ldac_len", dl, 4);
        check("single_idle", busy, 0);

        // All four held from reset
        drop = 0;
        sys_rst = 1;
        req = 4'b1111;
        repeat (3) step();
        sys_rst = 0;
        clear_mon();
        for (i = 0; i < 600 && ack_n < 5; i++) step();
        check("rr_nacks", ack_n, 5);
        check("rr_a0", ack_log[0], 4'b0001);
        check("rr_a1", ack_log[1], 4'b0010);
        check("rr_a2", ack_log[2], 4'b0100);
        check("rr_a3", ack_log[3], 4'b1000);
        check("rr_a4", ack_log[4], 4'b0001);
        for (int k = 1; k < 5; k++) check("rr_gap", ack_t[k] - ack_t[k-1], 101);

        // Pointer after ch1 grant favours ch0 over ch1
        req = 0;
        do_reset();
        req = 4'b0010;
        for (i = 0; i < 10 && ack_n < 1; i++) step();
        check("ptr_first", ack_log[0], 4'b0010);
        req = 4'b0011;
        for (i = 0; i < 200 && ack_n < 2; i++) step();
        check("ptr_next", ack_log[1], 4'b0001);

        // Reset at bit 5 of a word
        req = 0;
        do_reset();
        drop = 1;
        req = 4'b0001;
        step();
        repeat (42) step();
        check("midrst_shift", busy, 1);
        sys_rst = 1;
        step();
        sys_rst = 0;
        check("midrst_ioclk", DA_IO_CLK, 0);
        check("midrst_load", DA_LOAD, 1);
        check("midrst_ldac", DA_LDAC, 1);
        check("midrst_busy", busy, 0);
        clear_mon();
        repeat (100) step();
        check("midrst_noload", load_n + ldac_n, 0);
        req = 4'b0010;
        step();
        check("midrst_ack", ack, 4'b0010);
        wait_idle("midrst");

        // Data changed after capture does not disturb the word
        clear_mon();
        ch_data[7:0] = 8'h3C;
        ch_rng = 4'b0000;
        req = 4'b0001;
        step();
        check("stab_ack", ack, 4'b0001);
        step();
        step();
        ch_data[7:0] = 8'hFF;
        ch_rng = 4'b1111;
        wait_idle("stab");
        check("stab_bits", bits, 11'b00000111100);

        // Burst of three updates
        clear_mon();
        req = 4'b0111;
        step();
        wait_idle("burst");
        check("burst_loads", load_n, 3);
`ifdef TLC5620_SYNC_LDAC_EN
        check("burst_ldacs", ldac_n, 1);
`else
        check("burst_ldacs", ldac_n, 3);
`endif

        // Continuously held request: count loads until the second LDAC
        drop = 0;
        clear_mon();
        req = 4'b0001;
        for (i = 0; i < 1000 && ldac_n < 2; i++) step();
        check("held_ldacs", ldac_n, 2);
`ifdef TLC5620_SYNC_LDAC_EN
        check("held_loads", load_n, 8);
`else
        check("held_loads", load_n, 2);
`endif
        req = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end
endmodule
